// File: rtl/mbist_pkg.sv
// mbist_pkg: shared types and March C- element tables for the MBIST sequencer.
//   elem_e    : march element index M0..M5
//   state_e   : sequencer FSM states
//   elem_nops : operations per address in an element
//   elem_down : element walks addresses CAPACITY..0
//   op_we     : operation is a write (phase 0 = first op of the element)
//   op_val    : data pattern bit of the operation (0 = all-zeros, 1 = all-ones)
package mbist_pkg;

    typedef enum logic [2:0] {
        M0 = 3'd0,
        M1 = 3'd1,
        M2 = 3'd2,
        M3 = 3'd3,
        M4 = 3'd4,
        M5 = 3'd5
    } elem_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Covers the stage1 + two-stage compare delay of the last issued read.
    localparam int unsigned DRAIN_CYCLES = 3;

    function automatic logic [1:0] elem_nops(input elem_e e);
        return (e == M0 || e == M5) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic elem_down(input elem_e e);
        return (e == M3 || e == M4 || e == M5);
    endfunction

    // M0 is a lone write, M5 a lone read; the rest are read-then-write.
    function automatic logic op_we(input elem_e e, input logic ph);
        case (e)
            M0:      return 1'b1;
            M5:      return 1'b0;
            default: return ph;
        endcase
    endfunction

    // M1/M3: r0,w1   M2/M4: r1,w0   M0: w0   M5: r0
    function automatic logic op_val(input elem_e e, input logic ph);
        case (e)
            M1, M3:  return ph;
            M2, M4:  return ~ph;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// mbist_addr_gen: up/down address counter for one march element.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load_i       : load start address for direction down_i (0 or CAPACITY)
//   down_i       : direction applied on load
//   step_i       : advance one address in the loaded direction
//   addr_o       : current address
//   last_o       : current address is the final one of the walk
module mbist_addr_gen #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned CAPACITY   = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  down_i,
    input  logic                  step_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    localparam logic [ADDR_WIDTH-1:0] TOP = ADDR_WIDTH'(CAPACITY);

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  down_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
            down_q <= 1'b0;
        end else if (load_i) begin
            down_q <= down_i;
            addr_q <= down_i ? TOP : '0;
        end else if (step_i) begin
            addr_q <= down_q ? (addr_q - ADDR_WIDTH'(1)) : (addr_q + ADDR_WIDTH'(1));
        end
    end

    assign addr_o = addr_q;
    assign last_o = down_q ? (addr_q == '0) : (addr_q == TOP);

endmodule

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- MBIST sequencer for a single-port memory with a
// one-cycle wdata register and two-cycle read latency.
//   clk, rst          : clock (shared with memory), asynchronous active-high reset
//   start             : begin a test (accepted only in IDLE or DONE)
//   busy / done       : run in progress / run finished (level until next start)
//   fail              : sticky mismatch flag
//   fail_addr/bits/elem : address, expected^read mask and element of first mismatch
//   mem_write_read    : 1 = write, 0 = read
//   mem_address       : memory address
//   mem_wdata         : write data, one cycle ahead of its write command
//   mem_rdata         : memory read data
// Build option MBIST_DIAG_EN: never stop early; adds err_cnt (saturating count
// of all mismatching reads).
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned CAPACITY   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_bits,
    output logic [2:0]            fail_elem,
    output logic                  mem_write_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef MBIST_DIAG_EN
    ,
    output logic [15:0]           err_cnt
`endif
);

    state_e                state_q;
    elem_e                 elem_q, elem_d;
    logic                  ph_q;
    logic [1:0]            drain_cnt_q;
    logic                  busy_q, done_q, fail_q;
    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic [DATA_WIDTH-1:0] fail_bits_q;
    elem_e                 fail_elem_q;

    // Stage1 (drives the memory) and the two-stage compare delay.
    logic                  s1_we_q, s1_rv_q, d1_rv_q, d2_rv_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q, d1_addr_q, d2_addr_q;
    logic [DATA_WIDTH-1:0] s1_exp_q, d1_exp_q, d2_exp_q;
    elem_e                 s1_elem_q, d1_elem_q, d2_elem_q;

    logic                  gen_load, gen_down, gen_step, addr_last;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  start_ok, issue, stop, last_ph, mism;
    logic                  s0_we;
    logic [DATA_WIDTH-1:0] s0_data;

    mbist_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CAPACITY   (CAPACITY)
    ) u_addr_gen (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (gen_load),
        .down_i (gen_down),
        .step_i (gen_step),
        .addr_o (addr),
        .last_o (addr_last)
    );

    always_comb begin
        mism     = d2_rv_q && (mem_rdata != d2_exp_q);
        start_ok = start && (state_q == IDLE || state_q == DONE);
`ifdef MBIST_DIAG_EN
        stop     = 1'b0;
`else
        stop     = mism;
`endif
        issue    = (state_q == RUN) && !stop;
        last_ph  = ({1'b0, ph_q} == (elem_nops(elem_q) - 2'd1));
        s0_we    = op_we(elem_q, ph_q);
        s0_data  = {DATA_WIDTH{op_val(elem_q, ph_q)}};
        elem_d   = elem_e'(elem_q + 3'd1);
        gen_load = 1'b0;
        gen_down = 1'b0;
        gen_step = 1'b0;
        if (start_ok) begin
            gen_load = 1'b1;
            gen_down = elem_down(M0);
        end else if (issue && last_ph) begin
            if (!addr_last) begin
                gen_step = 1'b1;
            end else if (elem_q != M5) begin
                gen_load = 1'b1;
                gen_down = elem_down(elem_d);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            elem_q      <= M0;
            ph_q        <= 1'b0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_bits_q <= '0;
            fail_elem_q <= M0;
`ifdef MBIST_DIAG_EN
            err_cnt     <= '0;
`endif
        end else begin
            // Capture is first-mismatch only; in-flight reads after a stop
            // are still compared but cannot overwrite.
            if (mism && !fail_q) begin
                fail_q      <= 1'b1;
                fail_addr_q <= d2_addr_q;
                fail_bits_q <= mem_rdata ^ d2_exp_q;
                fail_elem_q <= d2_elem_q;
            end
`ifdef MBIST_DIAG_EN
            if (mism && err_cnt != '1) begin
                err_cnt <= err_cnt + 16'd1;
            end
`endif
            case (state_q)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state_q     <= RUN;
                        elem_q      <= M0;
                        ph_q        <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        fail_q      <= 1'b0;
                        fail_addr_q <= '0;
                        fail_bits_q <= '0;
                        fail_elem_q <= M0;
`ifdef MBIST_DIAG_EN
                        err_cnt     <= '0;
`endif
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q     <= DRAIN;
                        drain_cnt_q <= '0;
                    end else if (!last_ph) begin
                        ph_q <= 1'b1;
                    end else begin
                        ph_q <= 1'b0;
                        if (addr_last) begin
                            if (elem_q == M5) begin
                                state_q     <= DRAIN;
                                drain_cnt_q <= '0;
                            end else begin
                                elem_q <= elem_d;
                            end
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt_q <= drain_cnt_q + 2'd1;
                    if (drain_cnt_q == 2'(DRAIN_CYCLES - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_we_q   <= 1'b0;
            s1_rv_q   <= 1'b0;
            s1_addr_q <= '0;
            s1_exp_q  <= '0;
            s1_elem_q <= M0;
            d1_rv_q   <= 1'b0;
            d1_addr_q <= '0;
            d1_exp_q  <= '0;
            d1_elem_q <= M0;
            d2_rv_q   <= 1'b0;
            d2_addr_q <= '0;
            d2_exp_q  <= '0;
            d2_elem_q <= M0;
        end else begin
            s1_we_q   <= issue && s0_we;
            s1_rv_q   <= issue && !s0_we;
            s1_addr_q <= issue ? addr : '0;
            s1_exp_q  <= issue ? s0_data : '0;
            s1_elem_q <= elem_q;
            d1_rv_q   <= s1_rv_q;
            d1_addr_q <= s1_addr_q;
            d1_exp_q  <= s1_exp_q;
            d1_elem_q <= s1_elem_q;
            d2_rv_q   <= d1_rv_q;
            d2_addr_q <= d1_addr_q;
            d2_exp_q  <= d1_exp_q;
            d2_elem_q <= d1_elem_q;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign fail           = fail_q;
    assign fail_addr      = fail_addr_q;
    assign fail_bits      = fail_bits_q;
    assign fail_elem      = fail_elem_q;
    assign mem_write_read = s1_we_q;
    assign mem_address    = s1_addr_q;
    // Stage0 data goes out directly so the memory's wdata register holds it
    // when stage1 presents the matching write command.
    assign mem_wdata      = (state_q == RUN) ? s0_data : '0;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
module tb_mbist_march_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, fail, mem_write_read;
    logic [3:0] fail_addr, mem_address;
    logic [7:0] fail_bits, mem_wdata, mem_rdata;
    logic [2:0] fail_elem;
`ifdef MBIST_DIAG_EN
    logic [15:0] err_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CAPACITY(15)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .fail           (fail),
        .fail_addr      (fail_addr),
        .fail_bits      (fail_bits),
        .fail_elem      (fail_elem),
        .mem_write_read (mem_write_read),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
`ifdef MBIST_DIAG_EN
        ,
        .err_cnt        (err_cnt)
`endif
    );

    // Memory model: wdata register, write uses the registered data, 2-cycle read.
    logic [7:0] mem [16];
    logic [7:0] wd_q, rd1;
    bit         flt_en = 0;
    logic [3:0] flt_addr = '0;
    int         flt_bit = 0;
    logic       flt_val = 1'b0;

    function automatic logic [7:0] faulty(input logic [7:0] v, input logic [3:0] a);
        logic [7:0] r;
        r = v;
        if (flt_en && a == flt_addr) r[flt_bit] = flt_val;
        return r;
    endfunction

    always @(posedge clk) begin
        wd_q <= mem_wdata;
        if (mem_write_read) mem[mem_address] <= wd_q;
        rd1       <= faulty(mem[mem_address], mem_address);
        mem_rdata <= rd1;
    end

    // Reference March C- op stream.
    typedef struct {
        bit         we;
        logic [3:0] addr;
        logic [7:0] data;
    } op_t;
    op_t sb[$];

    int nops [6]    = '{1, 2, 2, 2, 2, 1};
    int dn   [6]    = '{0, 0, 0, 1, 1, 1};
    int wr   [6][2] = '{'{1, 0}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 0}};
    int pv   [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};

    task automatic build_ops();
        op_t o;
        sb.delete();
        for (int e = 0; e < 6; e++)
            for (int k = 0; k < 16; k++)
                for (int p = 0; p < nops[e]; p++) begin
                    o.we   = (wr[e][p] != 0);
                    o.addr = 4'(dn[e] != 0 ? 15 - k : k);
                    o.data = (pv[e][p] != 0) ? 8'hFF : 8'h00;
                    sb.push_back(o);
                end
    endtask

    function automatic logic [40:0] outs();
        logic [40:0] v;
        v = {busy, done, fail, fail_addr, fail_bits, fail_elem, mem_write_read,
             mem_address, mem_wdata, 1'b0};
`ifdef MBIST_DIAG_EN
        v[0] = |err_cnt;
`endif
        return v;
    endfunction

    // Runs one march from the current state; chk_ops also checks every op and
    // injects starts that must be ignored (in RUN and in DRAIN).
    task automatic run_march(input bit chk_ops, output int done_cyc);
        op_t        o;
        logic [7:0] wd_prev;
        done_cyc = -1;
        wd_prev  = '0;
        if (chk_ops) build_ops();
        @(negedge clk) start = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start = 1'b0;
                checks++;
                if ({busy, done, fail} !== 3'b100) begin
                    failures++;
                    $display("FAIL start_ack busy/done/fail=%b expected 100", {busy, done, fail});
                end
            end
            if (chk_ops && (cyc == 50 || cyc == 162)) start = 1'b1;
            if (chk_ops && (cyc == 51 || cyc == 163)) start = 1'b0;
            if (chk_ops && cyc >= 2 && sb.size() > 0) begin
                o = sb.pop_front();
                checks++;
                if (mem_write_read !== o.we || mem_address !== o.addr ||
                    (o.we && wd_prev !== o.data)) begin
                    failures++;
                    $display("FAIL op cyc=%0d got we=%b a=%0d wd=%h expected we=%b a=%0d wd=%h",
                             cyc, mem_write_read, mem_address, wd_prev, o.we, o.addr, o.data);
                end
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            wd_prev = mem_wdata;
        end
        checks++;
        if (done_cyc < 0 || (chk_ops && sb.size() != 0)) begin
            failures++;
            $display("FAIL run_end done_cyc=%0d ops_left=%0d expected done and 0 ops left",
                     done_cyc, sb.size());
        end
        checks++;
        if (busy !== 1'b0 || mem_write_read !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_done busy=%b we=%b expected 0 0", busy, mem_write_read);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (outs() !== '0) begin
            failures++;
            $display("FAIL reset_outputs got %h expected 0", outs());
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fault_free();
        int dc;
        flt_en = 0;
        run_march(1, dc);
        checks++;
        if (dc !== 164 || fail !== 1'b0) begin
            failures++;
            $display("FAIL fault_free done_cyc=%0d fail=%b expected 164 0", dc, fail);
        end
    endtask

    task automatic test_stuck(input logic [3:0] a, input int b, input logic v,
                              input logic [2:0] exp_elem, input int exp_done, input int exp_err);
        int dc;
        flt_en = 1; flt_addr = a; flt_bit = b; flt_val = v;
`ifdef MBIST_DIAG_EN
        run_march(1, dc);
        exp_done = 164;
        checks++;
        if (err_cnt !== 16'(exp_err)) begin
            failures++;
            $display("FAIL err_cnt got %0d expected %0d", err_cnt, exp_err);
        end
`else
        run_march(0, dc);
        if (exp_err < 0) exp_done = -1;
`endif
        checks++;
        if (dc !== exp_done) begin
            failures++;
            $display("FAIL stuck_done_cyc got %0d expected %0d", dc, exp_done);
        end
        checks++;
        if ({fail, fail_addr, fail_bits, fail_elem} !== {1'b1, a, 8'(1 << b), exp_elem}) begin
            failures++;
            $display("FAIL stuck_diag got fail=%b a=%0d bits=%h elem=%0d expected 1 %0d %h %0d",
                     fail, fail_addr, fail_bits, fail_elem, a, 8'(1 << b), exp_elem);
        end
        flt_en = 0;
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] snap [16];
        int dc;
        @(negedge clk) start = 1'b1;
        for (int cyc = 1; cyc <= 90; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
        end
        snap = mem;
        rst = 1'b1;
        #1;
        checks++;
        if (outs() !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs got %h expected 0", outs());
        end
        repeat (2) @(negedge clk);
        checks++;
        if (outs() !== '0 || mem != snap) begin
            failures++;
            $display("FAIL mid_reset_hold outs=%h mem_same=%0d expected 0 1", outs(), mem == snap);
        end
        rst = 1'b0;
        @(negedge clk);
        run_march(1, dc);
        checks++;
        if (dc !== 164 || fail !== 1'b0) begin
            failures++;
            $display("FAIL rerun_after_reset done_cyc=%0d fail=%b expected 164 0", dc, fail);
        end
    endtask

    initial begin
        test_reset();
        test_fault_free();
        // First r1 of M2 at address 5 is op 16+32+5*2=58 -> done at cycle 58+8.
        test_stuck(4'd5, 2, 1'b0, 3'd2, 66, 2);
        // First r0 of M1 at address 9 is op 16+9*2=34 -> done at cycle 34+8.
        test_stuck(4'd9, 0, 1'b1, 3'd1, 42, 3);
        test_fault_free();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
